// File: rtl/fp_i2f_pipe.sv
// fp_i2f_pipe: multi-lane integer to IEEE-style float converter.
// Sign/magnitude, normalise, field extract, then round and pack.
module fp_i2f_pipe #(
  parameter int IWIDTH = 16,
  parameter int EXP    = 5,
  parameter int MANT   = 10,
  parameter int WIDTH  = 1 + EXP + MANT,
  parameter int LANES  = 1
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [LANES*IWIDTH-1:0] dataa,
  input  logic                    signed_mode,
  input  logic                    round_mode,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [LANES*WIDTH-1:0]  result,
  output logic [LANES-1:0]        overflow,
  output logic [LANES-1:0]        inexact
);

  localparam int BIAS = 2**(EXP-1) - 1;
  localparam int PW   = $clog2(IWIDTH);
  localparam int NW   = IWIDTH - 1;
  localparam int FW   = IWIDTH + MANT + 1;
  localparam logic [31:0] EMAX = 32'(2**EXP - 1);

  logic                         en;
  logic                         v1_q, v2_q, v3_q, vo_q;
  logic                         rm1_q, rm2_q, rm3_q;

  logic [LANES-1:0]             sign1_d, sign1_q;
  logic [LANES-1:0][IWIDTH-1:0] mag1_d, mag1_q;

  logic [LANES-1:0]             sign2_q;
  logic [LANES-1:0][PW-1:0]     p2_d, p2_q;
  logic [LANES-1:0][NW-1:0]     norm2_d, norm2_q;
  logic [LANES-1:0]             zero2_d, zero2_q;

  logic [LANES-1:0]             sign3_q;
  logic [LANES-1:0][PW-1:0]     p3_q;
  logic [LANES-1:0][MANT-1:0]   mant3_d, mant3_q;
  logic [LANES-1:0]             guard3_d, guard3_q;
  logic [LANES-1:0]             sticky3_d, sticky3_q;
  logic [LANES-1:0]             zero3_q;

  logic [LANES-1:0][WIDTH-1:0]  res_d, res_q;
  logic [LANES-1:0]             ovf_d, ovf_q;
  logic [LANES-1:0]             inx_d, inx_q;

  assign en           = !vo_q | result_ready;
  assign data_ready   = en;
  assign result_valid = vo_q;
  assign result       = res_q;
  assign overflow     = ovf_q;
  assign inexact      = inx_q;

  always_comb begin
    sign1_d = '0;
    mag1_d  = '0;
    for (int k = 0; k < LANES; k++) begin
      sign1_d[k] = signed_mode & dataa[k*IWIDTH + IWIDTH - 1];
      mag1_d[k]  = sign1_d[k] ? -dataa[k*IWIDTH +: IWIDTH]
                              :  dataa[k*IWIDTH +: IWIDTH];
    end
  end

  // Leading-one position, then shift it out of the top bit.
  always_comb begin
    p2_d    = '0;
    norm2_d = '0;
    zero2_d = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < IWIDTH; i++) begin
        if (mag1_q[k][i]) p2_d[k] = PW'(i);
      end
      zero2_d[k] = ~|mag1_q[k];
      norm2_d[k] = NW'(mag1_q[k] << (PW'(IWIDTH - 1) - p2_d[k]));
    end
  end

  always_comb begin
    logic [FW-1:0] frac;
    frac      = '0;
    mant3_d   = '0;
    guard3_d  = '0;
    sticky3_d = '0;
    for (int k = 0; k < LANES; k++) begin
      frac         = {norm2_q[k], {(MANT + 2){1'b0}}};
      mant3_d[k]   = frac[FW-1 -: MANT];
      guard3_d[k]  = frac[FW-1-MANT];
      sticky3_d[k] = |frac[FW-2-MANT:0];
    end
  end

  always_comb begin
    logic            inc;
    logic [MANT:0]   mant_r;
    logic [31:0]     e;
    inc    = 1'b0;
    mant_r = '0;
    e      = '0;
    res_d  = '0;
    ovf_d  = '0;
    inx_d  = '0;
    for (int k = 0; k < LANES; k++) begin
      inc    = !rm3_q & guard3_q[k] & (sticky3_q[k] | mant3_q[k][0]);
      mant_r = {1'b0, mant3_q[k]} + {{MANT{1'b0}}, inc};
      e      = 32'(p3_q[k]) + 32'(mant_r[MANT]) + 32'(BIAS);
      if (!zero3_q[k]) begin
        inx_d[k] = guard3_q[k] | sticky3_q[k];
        if (e >= EMAX) begin
          res_d[k] = {sign3_q[k], {EXP{1'b1}}, {MANT{1'b0}}};
          ovf_d[k] = 1'b1;
        end else begin
          res_d[k] = {sign3_q[k], e[EXP-1:0], mant_r[MANT-1:0]};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      vo_q      <= 1'b0;
      rm1_q     <= 1'b0;
      rm2_q     <= 1'b0;
      rm3_q     <= 1'b0;
      sign1_q   <= '0;
      mag1_q    <= '0;
      sign2_q   <= '0;
      p2_q      <= '0;
      norm2_q   <= '0;
      zero2_q   <= '0;
      sign3_q   <= '0;
      p3_q      <= '0;
      mant3_q   <= '0;
      guard3_q  <= '0;
      sticky3_q <= '0;
      zero3_q   <= '0;
      res_q     <= '0;
      ovf_q     <= '0;
      inx_q     <= '0;
    end else if (en) begin
      v1_q      <= data_valid;
      rm1_q     <= round_mode;
      sign1_q   <= sign1_d;
      mag1_q    <= mag1_d;
      v2_q      <= v1_q;
      rm2_q     <= rm1_q;
      sign2_q   <= sign1_q;
      p2_q      <= p2_d;
      norm2_q   <= norm2_d;
      zero2_q   <= zero2_d;
      v3_q      <= v2_q;
      rm3_q     <= rm2_q;
      sign3_q   <= sign2_q;
      p3_q      <= p2_q;
      mant3_q   <= mant3_d;
      guard3_q  <= guard3_d;
      sticky3_q <= sticky3_d;
      zero3_q   <= zero2_q;
      vo_q      <= v3_q;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      inx_q     <= inx_d;
    end
  end

endmodule
